imem_responder: RTL and testbench
=================================

Name: imem_responder

Overview:
Responder end of the fetch-to-instruction-memory interface. Accepts one fetch request at a time using a byte address (word-aligned, PC increments by 2). Returns the 16-bit instruction after a fixed, programmable latency, using a valid/ready response handshake. Also provides a program-load write port and a flush input that discards an in-flight fetch on a PC redirect.

Parameters:
DEPTH_WORDS, 256, number of 16-bit instruction words; byte address range is 0 .. 2*DEPTH_WORDS-1
LATENCY, 2, cycles from request acceptance to rsp_valid assertion; legal range 1..15
ERR_INSTR, 16'h0000, value driven on rsp_instr for an error response

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous assert, active-low (0 = reset)
req_valid  in  1  fetch request present
req_ready  out  1  responder can accept a request this cycle
req_addr  in  16  byte address of the instruction
rsp_valid  out  1  response present
rsp_ready  in  1  fetch stage consumes the response
rsp_instr  out  16  instruction word
rsp_err  out  1  misaligned or out-of-range address
flush  in  1  abandon the in-flight or pending transaction
ld_en  in  1  program-load write enable
ld_addr  in  16  byte address for the load write
ld_data  in  16  load data
busy  out  1  a transaction is in WAIT or RESP

Behaviour:
- Reset (rst=0): state=IDLE, req_ready=0 while in reset, rsp_valid=0, rsp_instr=0, rsp_err=0, busy=0, counter=0. Memory contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = ~flush.
  - Accept when req_valid & req_ready: latch the address and compute err = addr[0] | (addr[15:1] >= DEPTH_WORDS).
  - If LATENCY==1, go to RESP. Otherwise go to WAIT with cnt = LATENCY-2.
- WAIT:
  - req_ready=0.
  - cnt decrements each cycle. When cnt==0, go to RESP.
- Entering RESP: rsp_instr = err ? ERR_INSTR : mem[addr[15:1]], sampled on the transition edge. rsp_err = err.
- RESP:
  - rsp_valid=1. rsp_instr and rsp_err are held stable until rsp_valid & rsp_ready.
  - On handshake, go to IDLE. rsp_valid falls the next cycle.
  - No request is accepted in the same cycle as the handshake.
- Latency: a request accepted at edge N gives rsp_valid=1 in the cycle after edge N+LATENCY-1, i.e. LATENCY cycles after acceptance. The minimum back-to-back issue interval is LATENCY+1 cycles.
- flush:
  - In WAIT or RESP: go to IDLE next edge, no response produced, rsp_valid=0 next cycle.
  - flush and rsp_ready in the same RESP cycle: treated as flush; the response is counted as not consumed.
  - In IDLE: blocks acceptance.
- Error responses use the same latency and handshake as normal responses. The fetch stage decides the trap.
- Load port:
  - Writes mem[ld_addr[15:1]] = ld_data on any edge when ld_en=1 and the address is in range and aligned. Otherwise the write is silently dropped.
  - Legal in any state.
  - A load to the word being fetched, landing on or before the RESP-entry edge, is reflected in rsp_instr (write-before-read on the same edge, forwarded).
- Reset mid-transaction: immediate return to IDLE, outputs to reset values, no response.
- Address width: word index = addr[15:1]. Index compare is unsigned against DEPTH_WORDS.

Decomposition:
- Shared package imem_pkg:
  - FSM state typedef (IDLE, WAIT, RESP).
  - Constants IMEM_DEPTH_WORDS and IMEM_ERR_INSTR.
  - Request/response field widths (16).
- One natural sub-module: imem_array. It holds the DEPTH_WORDS x 16 storage with one synchronous write port and one combinational read port plus write-to-read forwarding. The FSM, counter and error check stay in imem_responder.

Test Plan:
- Load mem[0..3]=16'hA001,16'hB002,16'hC003,16'hD004; LATENCY=2; req 0x0002 with rsp_ready=1 -> rsp_valid 2 cycles after accept, rsp_instr=16'hB002, rsp_err=0, one-cycle pulse.
- req 0x0003 (misaligned), then req 0x0200 with DEPTH_WORDS=256 -> each responds with rsp_err=1, rsp_instr=16'h0000, same latency.
- req 0x0004, hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_instr=16'hC003 stable all 5 cycles; req_ready=0 throughout; IDLE one cycle after the handshake.
- req 0x0006, assert flush in the WAIT cycle -> no rsp_valid ever; req_ready=1 the cycle after flush; next req 0x0000 returns 16'hA001.
- ld_en writing 0x0004 <- 16'h1234 on the RESP-entry edge of a fetch to 0x0004 -> rsp_instr=16'h1234.
- Assert rst=0 while in RESP -> rsp_valid=0 and busy=0 immediately (asynchronous); after release, mem[0] still 16'hA001.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder slice.
// Holds the FSM state encoding, default geometry and the address legality check.
package imem_pkg;

  localparam int unsigned IMEM_ADDR_W      = 16;
  localparam int unsigned IMEM_DATA_W      = 16;
  localparam int unsigned IMEM_DEPTH_WORDS = 256;
  localparam logic [IMEM_DATA_W-1:0] IMEM_ERR_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } imem_state_t;

  // A byte address is unusable when it is odd or its word index falls past the array.
  function automatic logic addr_is_bad(input logic [IMEM_ADDR_W-1:0] addr,
                                       input int unsigned depth_words);
    return addr[0] | (32'(addr[IMEM_ADDR_W-1:1]) >= depth_words);
  endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one synchronous write port, one combinational read port.
// A write landing on the same edge as a read of that word is forwarded to the reader.
module imem_array
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = IMEM_DEPTH_WORDS,
  parameter int unsigned IDX_W       = 8
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [IMEM_DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]       rd_idx,
  output logic [IMEM_DATA_W-1:0] rd_data
);

  logic [IMEM_DATA_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = (wr_en && (wr_idx == rd_idx)) ? wr_data : mem[rd_idx];

endmodule

// File: rtl/imem_responder.sv
// Responder end of the fetch/instruction-memory link: single outstanding fetch,
// fixed programmable latency, valid/ready response, program-load port and flush.
module imem_responder
  import imem_pkg::*;
#(
  parameter int unsigned             DEPTH_WORDS = IMEM_DEPTH_WORDS,
  parameter int unsigned             LATENCY     = 2,
  parameter logic [IMEM_DATA_W-1:0] ERR_INSTR   = IMEM_ERR_INSTR
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [IMEM_ADDR_W-1:0] req_addr,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IMEM_DATA_W-1:0] rsp_instr,
  output logic                   rsp_err,
  input  logic                   flush,
  input  logic                   ld_en,
  input  logic [IMEM_ADDR_W-1:0] ld_addr,
  input  logic [IMEM_DATA_W-1:0] ld_data,
  output logic                   busy
);

  localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  imem_state_t            state;
  logic [3:0]             cnt;
  logic [IDX_W-1:0]       idx_q;
  logic                   err_q;
  logic                   req_err;
  logic                   accept;
  logic                   ld_ok;
  logic                   ent_err;
  logic [IDX_W-1:0]       rd_idx;
  logic [IMEM_DATA_W-1:0] rd_data;
  logic [IMEM_DATA_W-1:0] ent_instr;

  assign req_err   = addr_is_bad(req_addr, DEPTH_WORDS);
  assign ld_ok     = ld_en & ~addr_is_bad(ld_addr, DEPTH_WORDS);
  assign req_ready = rst & (state == ST_IDLE) & ~flush;
  assign accept    = req_valid & req_ready;

  // With LATENCY==1 RESP is entered on the accept edge itself, so the read must
  // come straight from the request bus rather than the latched index.
  assign rd_idx    = (state == ST_IDLE) ? req_addr[IDX_W:1] : idx_q;
  assign ent_err   = (state == ST_IDLE) ? req_err : err_q;
  assign ent_instr = ent_err ? ERR_INSTR : rd_data;

  imem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk     (clk),
    .wr_en   (ld_ok),
    .wr_idx  (ld_addr[IDX_W:1]),
    .wr_data (ld_data),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_instr <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            idx_q <= req_addr[IDX_W:1];
            err_q <= req_err;
            busy  <= 1'b1;
            if (LATENCY == 1) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_instr <= ent_instr;
              rsp_err   <= ent_err;
            end else begin
              state <= ST_WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (flush) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (cnt == 4'd0) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_instr <= ent_instr;
            rsp_err   <= ent_err;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          // Flush wins over a simultaneous consume: the response is dropped.
          if (flush || rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: directed scenarios with literal values
// plus randomized traffic compared every cycle against a transaction-level model.
module tb_imem_responder;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned LAT   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_addr = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_instr;
  logic        rsp_err;
  logic        flush = 1'b0;
  logic        ld_en = 1'b0;
  logic [15:0] ld_addr = '0;
  logic [15:0] ld_data = '0;
  logic        busy;

  int tests = 0;
  int fails = 0;

  imem_responder #(
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT),
    .ERR_INSTR   (16'h0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_instr (rsp_instr),
    .rsp_err   (rsp_err),
    .flush     (flush),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a fetch is "in flight" for LAT edges counted from its
  // accept edge, then "shown" until consumed or flushed.
  logic [15:0] m_mem [DEPTH];
  bit          m_inflight = 0;
  bit          m_shown = 0;
  int          m_age = 0;
  logic [15:0] m_addr = '0;
  bit          m_bad = 0;
  logic [15:0] m_instr = '0;
  bit          m_err = 0;

  function automatic bit bad_addr(input logic [15:0] a);
    return (a[0] == 1'b1) || (int'(a >> 1) >= int'(DEPTH));
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_inflight = 0;
      m_shown    = 0;
      m_age      = 0;
    end else begin
      if (ld_en && !bad_addr(ld_addr)) m_mem[int'(ld_addr >> 1)] = ld_data;
      if (m_shown) begin
        if (flush || rsp_ready) m_shown = 0;
      end else if (m_inflight) begin
        if (flush) m_inflight = 0;
        else m_age++;
      end else if (req_valid && !flush) begin
        m_addr     = req_addr;
        m_bad      = bad_addr(req_addr);
        m_inflight = 1;
        m_age      = 1;
      end
      if (m_inflight && m_age == int'(LAT)) begin
        m_inflight = 0;
        m_shown    = 1;
        m_err      = m_bad;
        m_instr    = m_bad ? 16'h0000 : m_mem[int'(m_addr >> 1)];
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk1("cyc_rsp_valid", rsp_valid, m_shown);
      chk1("cyc_busy", busy, m_inflight || m_shown);
      chk1("cyc_req_ready", req_ready, !(m_inflight || m_shown) && !flush);
      if (m_shown) begin
        chk16("cyc_rsp_instr", rsp_instr, m_instr);
        chk1("cyc_rsp_err", rsp_err, m_err);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [15:0] a);
    req_valid = 1'b1;
    req_addr  = a;
    #1;
    chk1("issue_ready", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic load(input logic [15:0] a, input logic [15:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  initial begin
    // Reset values while rst is held low.
    tick();
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk16("rst_rsp_instr", rsp_instr, 16'h0000);
    chk1("rst_rsp_err", rsp_err, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_req_ready", req_ready, 1'b0);
    tick();
    rst = 1'b1;
    tick();

    for (int i = 0; i < int'(DEPTH); i++) load(16'(i * 2), 16'($urandom));
    load(16'h0000, 16'hA001);
    load(16'h0002, 16'hB002);
    load(16'h0004, 16'hC003);
    load(16'h0006, 16'hD004);

    // Basic fetch: response two cycles after accept, one-cycle pulse.
    rsp_ready = 1'b1;
    issue(16'h0002);
    chk1("t1_wait_valid", rsp_valid, 1'b0);
    chk1("t1_wait_busy", busy, 1'b1);
    tick();
    chk1("t1_valid", rsp_valid, 1'b1);
    chk16("t1_instr", rsp_instr, 16'hB002);
    chk1("t1_err", rsp_err, 1'b0);
    chk16("t1_model", m_instr, 16'hB002);
    tick();
    chk1("t1_pulse_end", rsp_valid, 1'b0);

    // Misaligned and out-of-range addresses.
    issue(16'h0003);
    tick();
    chk1("t2a_valid", rsp_valid, 1'b1);
    chk1("t2a_err", rsp_err, 1'b1);
    chk16("t2a_instr", rsp_instr, 16'h0000);
    tick();
    issue(16'h0200);
    chk1("t2b_early", rsp_valid, 1'b0);
    tick();
    chk1("t2b_valid", rsp_valid, 1'b1);
    chk1("t2b_err", rsp_err, 1'b1);
    chk16("t2b_instr", rsp_instr, 16'h0000);
    tick();

    // Backpressure: response held stable.
    rsp_ready = 1'b0;
    issue(16'h0004);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk1("t3_valid_hold", rsp_valid, 1'b1);
      chk16("t3_instr_hold", rsp_instr, 16'hC003);
      chk1("t3_ready_low", req_ready, 1'b0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk1("t3_after_valid", rsp_valid, 1'b0);
    chk1("t3_after_busy", busy, 1'b0);
    chk1("t3_after_ready", req_ready, 1'b1);

    // Flush during WAIT: no response ever.
    issue(16'h0006);
    flush = 1'b1;
    #1;
    chk1("t4_ready_wait", req_ready, 1'b0);
    tick();
    flush = 1'b0;
    #1;
    chk1("t4_ready_after", req_ready, 1'b1);
    chk1("t4_busy_after", busy, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk1("t4_no_valid", rsp_valid, 1'b0);
      tick();
    end
    issue(16'h0000);
    tick();
    chk16("t4_next_instr", rsp_instr, 16'hA001);
    tick();

    // Load landing on the RESP-entry edge is forwarded.
    issue(16'h0004);
    ld_en   = 1'b1;
    ld_addr = 16'h0004;
    ld_data = 16'h1234;
    tick();
    ld_en = 1'b0;
    chk1("t5_valid", rsp_valid, 1'b1);
    chk16("t5_instr", rsp_instr, 16'h1234);
    tick();

    // Asynchronous reset while in RESP.
    rsp_ready = 1'b0;
    issue(16'h0000);
    tick();
    chk1("t6_valid_pre", rsp_valid, 1'b1);
    rst = 1'b0;
    #1;
    chk1("t6_valid_rst", rsp_valid, 1'b0);
    chk1("t6_busy_rst", busy, 1'b0);
    chk1("t6_ready_rst", req_ready, 1'b0);
    chk16("t6_instr_rst", rsp_instr, 16'h0000);
    tick();
    tick();
    rst = 1'b1;
    rsp_ready = 1'b1;
    tick();
    issue(16'h0000);
    tick();
    chk16("t6_mem_kept", rsp_instr, 16'hA001);
    tick();

    // Randomized traffic; the per-cycle compare process does the checking.
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 7)       req_addr = 16'($urandom_range(0, DEPTH - 1) * 2);
      else if (r == 7) req_addr = 16'($urandom_range(0, DEPTH - 1) * 2 + 1);
      else             req_addr = 16'($urandom);
      req_valid = ($urandom_range(0, 1) == 1);
      rsp_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 99) < 8);
      ld_en     = ($urandom_range(0, 4) == 0);
      ld_addr   = ($urandom_range(0, 9) < 8) ? 16'($urandom_range(0, DEPTH - 1) * 2)
                                             : 16'($urandom);
      ld_data   = 16'($urandom);
      tick();
    end
    req_valid = 1'b0;
    flush     = 1'b0;
    ld_en     = 1'b0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
